// File: rtl/cgra_seq_pkg.sv
// Shared types and constants for the CGRA job sequencer.
package cgra_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_REQ,
    CFG_WAIT,
    CFG_PUSH,
    RUN
  } seq_state_t;

  localparam logic [31:0] PERF_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cgra_sat_counter.sv
// 32-bit performance counter that sticks at all-ones; clear beats increment.
module cgra_sat_counter
  import cgra_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_count <= '0;
    else if (i_clr)                           r_count <= '0;
    else if (i_inc && (r_count != PERF_SAT))  r_count <= r_count + 32'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/cgra_job_sequencer.sv
// Loads a CGRA bitstream from memory into the fabric config port, then
// launches execution and watches for completion or timeout.
module cgra_job_sequencer
  import cgra_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_CFG_WORDS  = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cgra_start,
  input  logic                  cgra_reset,
  input  logic [ADDR_WIDTH-1:0] bitstream_addr,
  input  logic [15:0]           bitstream_size,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rerr,
  output logic                  cfg_valid,
  output logic [31:0]           cfg_data,
  input  logic                  cfg_ready,
  output logic                  fabric_start,
  input  logic                  fabric_done,
  output logic                  cgra_busy,
  output logic                  cgra_done,
  output logic                  cgra_error,
  output logic                  cfg_done,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
);

  localparam logic [16:0] MAX_W    = 17'(MAX_CFG_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  seq_state_t            r_state, w_nstate;
  logic                  r_cfg_prev, r_run_prev;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [15:0]           r_size, r_idx;
  logic [31:0]           r_cfg_data;
  logic                  r_busy, r_done, r_err, r_cfg_done, r_fabric_start;

  logic w_cfg_edge, w_run_edge, w_size_ok;
  logic w_load, w_launch, w_set_err, w_set_done, w_set_cfg_done, w_take_data, w_idx_inc;
  logic w_stall;
  logic [31:0] w_perf_cycles;

  assign w_cfg_edge = cfg_start & ~r_cfg_prev;
  assign w_run_edge = cgra_start & ~r_run_prev;
  assign w_size_ok  = (bitstream_size != 16'd0) && ({1'b0, bitstream_size} <= MAX_W);

  always_comb begin
    w_nstate       = r_state;
    w_load         = 1'b0;
    w_launch       = 1'b0;
    w_set_err      = 1'b0;
    w_set_done     = 1'b0;
    w_set_cfg_done = 1'b0;
    w_take_data    = 1'b0;
    w_idx_inc      = 1'b0;
    if (cgra_reset) begin
      w_nstate = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // cfg edge shadows a simultaneous start edge
          if (w_cfg_edge) begin
            if (w_size_ok) begin
              w_load   = 1'b1;
              w_nstate = CFG_REQ;
            end else begin
              w_set_err = 1'b1;
            end
          end else if (w_run_edge) begin
            if (r_cfg_done) begin
              w_launch = 1'b1;
              w_nstate = RUN;
            end else begin
              w_set_err = 1'b1;
            end
          end
        end
        CFG_REQ: if (mem_gnt) w_nstate = CFG_WAIT;
        CFG_WAIT: begin
          if (mem_rvalid) begin
            if (mem_rerr) begin
              w_set_err = 1'b1;
              w_nstate  = IDLE;
            end else begin
              w_take_data = 1'b1;
              w_nstate    = CFG_PUSH;
            end
          end
        end
        CFG_PUSH: begin
          if (cfg_ready) begin
            w_idx_inc = 1'b1;
            if (16'(r_idx + 16'd1) == r_size) begin
              w_set_cfg_done = 1'b1;
              w_nstate       = IDLE;
            end else begin
              w_nstate = CFG_REQ;
            end
          end
        end
        RUN: begin
          // perf_cycles doubles as the run timer; done beats timeout
          if (fabric_done) begin
            w_set_done = 1'b1;
            w_nstate   = IDLE;
          end else if (w_perf_cycles == TMO_LAST) begin
            w_set_err = 1'b1;
            w_nstate  = IDLE;
          end
        end
        default: w_nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cfg_prev     <= 1'b0;
      r_run_prev     <= 1'b0;
      r_base         <= '0;
      r_size         <= '0;
      r_idx          <= '0;
      r_cfg_data     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_cfg_done     <= 1'b0;
      r_fabric_start <= 1'b0;
    end else begin
      r_state        <= w_nstate;
      r_cfg_prev     <= cfg_start;
      r_run_prev     <= cgra_start;
      r_busy         <= (w_nstate != IDLE);
      r_fabric_start <= w_launch;
      if (cgra_reset) begin
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_cfg_done <= 1'b0;
        r_idx      <= '0;
      end else begin
        if (w_load) begin
          r_base     <= bitstream_addr;
          r_size     <= bitstream_size;
          r_idx      <= '0;
          r_cfg_done <= 1'b0;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
        end
        if (w_launch)       r_done     <= 1'b0;
        if (w_set_err)      r_err      <= 1'b1;
        if (w_set_done)     r_done     <= 1'b1;
        if (w_set_cfg_done) r_cfg_done <= 1'b1;
        if (w_take_data)    r_cfg_data <= mem_rdata;
        if (w_idx_inc)      r_idx      <= r_idx + 16'd1;
      end
    end
  end

  assign w_stall = ((r_state == CFG_REQ) && !mem_gnt) || (r_state == CFG_WAIT) ||
                   ((r_state == CFG_PUSH) && !cfg_ready);

  cgra_sat_counter u_cycles (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (cgra_reset | w_launch),
    .i_inc  (r_state == RUN),
    .o_count(w_perf_cycles)
  );

  cgra_sat_counter u_stalls (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (cgra_reset | w_load),
    .i_inc  (w_stall),
    .o_count(perf_stalls)
  );

  // soft reset drops handshakes in the same cycle so nothing new is accepted
  assign mem_req      = (r_state == CFG_REQ) & ~cgra_reset;
  assign mem_addr     = r_base + ADDR_WIDTH'({r_idx, 2'b00});
  assign cfg_valid    = (r_state == CFG_PUSH) & ~cgra_reset;
  assign cfg_data     = r_cfg_data;
  assign fabric_start = r_fabric_start & ~cgra_reset;
  assign cgra_busy    = r_busy;
  assign cgra_done    = r_done;
  assign cgra_error   = r_err;
  assign cfg_done     = r_cfg_done;
  assign perf_cycles  = w_perf_cycles;

endmodule

// File: tb/tb_cgra_job_sequencer.sv
// Scoreboard bench: expected addresses/config words are queued at stimulus
// time and consumed by the memory and fabric models as the DUT produces them.
module tb_cgra_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0, cgra_start = 1'b0, cgra_reset = 1'b0;
  logic [31:0] bitstream_addr = '0;
  logic [15:0] bitstream_size = '0;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_rerr = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0;
  logic        cfg_valid, cfg_ready = 1'b1;
  logic [31:0] cfg_data;
  logic        fabric_start, fabric_done = 1'b0;
  logic        cgra_busy, cgra_done, cgra_error, cfg_done;
  logic [31:0] perf_cycles, perf_stalls;

  always #5 clk = ~clk;

  cgra_job_sequencer #(.ADDR_WIDTH(32), .MAX_CFG_WORDS(1024), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cgra_start(cgra_start),
    .cgra_reset(cgra_reset), .bitstream_addr(bitstream_addr), .bitstream_size(bitstream_size),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rerr(mem_rerr), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .fabric_start(fabric_start), .fabric_done(fabric_done),
    .cgra_busy(cgra_busy), .cgra_done(cgra_done), .cgra_error(cgra_error), .cfg_done(cfg_done),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  int n_total = 0, n_bad = 0;
  logic [31:0] addr_q[$], data_q[$], exp_q[$];
  int gnt_dly = 0, rv_dly = 0, stall_left = 0;
  logic rerr_next = 1'b0;
  int req_seen = 0, busy_seen = 0, fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory model: fixed grant/data latency, returns queued words in order
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      if (addr_q.size() == 0) chk("addr_unexp", {31'b0, mem_req}, 32'd0);
      else chk("mem_addr", mem_addr, addr_q.pop_front());
      repeat (gnt_dly) @(negedge clk);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      repeat (rv_dly) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = (data_q.size() > 0) ? data_q.pop_front() : 32'h0;
      mem_rerr   = rerr_next;
      rerr_next  = 1'b0;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rerr   = 1'b0;
    end
  end

  // fabric config sink with optional initial backpressure
  initial forever begin
    @(negedge clk);
    if (cfg_valid) begin
      if (exp_q.size() == 0) begin
        chk("cfg_unexp", {31'b0, cfg_valid}, 32'd0);
        cfg_ready = 1'b1;
      end else if (stall_left > 0) begin
        cfg_ready = 1'b0;
        stall_left--;
        chk("cfg_hold", cfg_data, exp_q[0]);
      end else begin
        cfg_ready = 1'b1;
        chk("cfg_data", cfg_data, exp_q.pop_front());
      end
    end else begin
      cfg_ready = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_req)      req_seen++;
    if (cgra_busy)    busy_seen++;
    if (fabric_start) fs_cnt++;
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cgra_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, cgra_busy}, 32'd0);
  endtask

  task automatic soft_reset();
    @(negedge clk) cgra_reset = 1'b1;
    @(negedge clk) cgra_reset = 1'b0;
  endtask

  task automatic start_cfg(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    bitstream_addr = a;
    bitstream_size = n;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, cgra_busy}, 32'd0);
    chk("rst_err", {31'b0, cgra_error}, 32'd0);
    chk("rst_cfgdone", {31'b0, cfg_done}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_perf", perf_cycles | perf_stalls, 32'd0);
    rst_n = 1'b1;
    req_seen = 0; busy_seen = 0;

    // start without config, then illegal sizes
    @(negedge clk) cgra_start = 1'b1;
    @(negedge clk) cgra_start = 1'b0;
    chk("start_nocfg_err", {31'b0, cgra_error}, 32'd1);
    soft_reset();
    chk("softrst_err", {31'b0, cgra_error}, 32'd0);
    start_cfg(32'h1000, 16'd0);
    chk("size0_err", {31'b0, cgra_error}, 32'd1);
    soft_reset();
    start_cfg(32'h1000, 16'd1025);
    chk("size_big_err", {31'b0, cgra_error}, 32'd1);
    @(negedge clk);
    chk("illegal_busy", busy_seen, 0);
    chk("illegal_req", req_seen, 0);

    // basic load: grant after 1 cycle, data 2 cycles after grant
    gnt_dly = 1; rv_dly = 2;
    addr_q = '{32'h1000, 32'h1004, 32'h1008};
    data_q = '{32'hA, 32'hB, 32'hC};
    exp_q  = '{32'hA, 32'hB, 32'hC};
    @(negedge clk);
    bitstream_addr = 32'h1000; bitstream_size = 16'd3; cfg_start = 1'b1;
    @(negedge clk);
    chk("req_latency", {31'b0, mem_req}, 32'd1);
    cfg_start = 1'b0;
    wait_idle("basic_idle");
    chk("basic_cfgdone", {31'b0, cfg_done}, 32'd1);
    chk("basic_err", {31'b0, cgra_error}, 32'd0);
    chk("basic_stalls", perf_stalls, 32'd12);
    chk("basic_addr_left", addr_q.size(), 0);
    chk("basic_data_left", exp_q.size(), 0);

    // run with fabric_done in the 10th run cycle
    fs_cnt = 0;
    @(negedge clk) cgra_start = 1'b1;
    @(negedge clk) cgra_start = 1'b0;
    repeat (9) @(negedge clk);
    fabric_done = 1'b1;
    @(negedge clk) fabric_done = 1'b0;
    chk("run_done", {31'b0, cgra_done}, 32'd1);
    chk("run_cycles", perf_cycles, 32'd10);
    chk("run_fs_pulse", fs_cnt, 1);
    chk("run_busy", {31'b0, cgra_busy}, 32'd0);
    chk("run_err", {31'b0, cgra_error}, 32'd0);

    // timeout at 20 run cycles
    @(negedge clk) cgra_start = 1'b1;
    @(negedge clk) cgra_start = 1'b0;
    repeat (19) @(negedge clk);
    chk("tmo_early", {31'b0, cgra_error}, 32'd0);
    chk("tmo_busy", {31'b0, cgra_busy}, 32'd1);
    @(negedge clk);
    chk("tmo_err", {31'b0, cgra_error}, 32'd1);
    chk("tmo_idle", {31'b0, cgra_busy}, 32'd0);
    chk("tmo_cycles", perf_cycles, 32'd20);
    chk("tmo_done", {31'b0, cgra_done}, 32'd0);

    // asynchronous reset between clock edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_err", {31'b0, cgra_error}, 32'd0);
    chk("arst_cfgdone", {31'b0, cfg_done}, 32'd0);
    chk("arst_cycles", perf_cycles, 32'd0);
    chk("arst_stalls", perf_stalls, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // address wrap with 5 cycles of backpressure on the first word
    gnt_dly = 0; rv_dly = 0; stall_left = 5;
    addr_q = '{32'hFFFF_FFFC, 32'h0};
    data_q = '{32'h11, 32'h22};
    exp_q  = '{32'h11, 32'h22};
    start_cfg(32'hFFFF_FFFC, 16'd2);
    wait_idle("wrap_idle");
    chk("wrap_cfgdone", {31'b0, cfg_done}, 32'd1);
    chk("wrap_stalls", perf_stalls, 32'd7);
    chk("wrap_addr_left", addr_q.size(), 0);

    // cfg and start rise together: load only
    fs_cnt = 0;
    addr_q = '{32'h200};
    data_q = '{32'h55};
    exp_q  = '{32'h55};
    @(negedge clk);
    bitstream_addr = 32'h200; bitstream_size = 16'd1;
    cfg_start = 1'b1; cgra_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cgra_start = 1'b0;
    wait_idle("simul_idle");
    chk("simul_fs", fs_cnt, 0);
    chk("simul_err", {31'b0, cgra_error}, 32'd0);
    chk("simul_cfgdone", {31'b0, cfg_done}, 32'd1);
    chk("simul_data_left", exp_q.size(), 0);

    // read error aborts the load
    addr_q = '{32'h400};
    data_q = '{32'h77};
    rerr_next = 1'b1;
    start_cfg(32'h400, 16'd2);
    wait_idle("rerr_idle");
    chk("rerr_err", {31'b0, cgra_error}, 32'd1);
    chk("rerr_cfgdone", {31'b0, cfg_done}, 32'd0);

    // soft reset while waiting for read data; late data must be dropped
    rv_dly = 5;
    addr_q = '{32'h3000};
    data_q = '{32'hDEAD};
    @(negedge clk);
    bitstream_addr = 32'h3000; bitstream_size = 16'd2; cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
    @(negedge clk) cgra_reset = 1'b1;
    @(negedge clk) cgra_reset = 1'b0;
    chk("midrst_busy", {31'b0, cgra_busy}, 32'd0);
    repeat (8) @(negedge clk);
    chk("midrst_busy2", {31'b0, cgra_busy}, 32'd0);
    chk("midrst_err", {31'b0, cgra_error}, 32'd0);
    chk("midrst_cfgdone", {31'b0, cfg_done}, 32'd0);
    chk("midrst_done", {31'b0, cgra_done}, 32'd0);
    chk("midrst_stalls", perf_stalls, 32'd0);
    chk("midrst_addr_left", addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
